add_sub_arb_25519: RTL

ADD_SUB_ARB_25519 -- requirements
Module: add_sub_arb_25519

---
 rtl/add_sub_arb_25519.sv | 98 +++++++++
 1 files changed

// File: rtl/add_sub_arb_25519.sv
// add_sub_arb_25519: round-robin arbitrated modular add/subtract unit over p = 2^255-19
// Define ADD_SUB_ARB_RANGE_CHK_EN to flag operands >= p (rsp_err = 1, rsp_data = 0).
module add_sub_arb_25519 #(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*256-1:0] req_a,
  input  logic [NREQ*256-1:0] req_b,
  input  logic [NREQ-1:0]     req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2:0]          rsp_id,
  output logic [255:0]        rsp_data,
  output logic                rsp_err,
  output logic                busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [IW-1:0] last_q, gnt_idx;
  logic          gnt_any, hs, op_q, err_q, err_d;
  logic [255:0]  a_q, b_q, ga, gb, res;
  logic [256:0]  sum;
  logic          rsp_valid_q, rsp_err_q;
  logic [255:0]  rsp_data_q;
  logic [IW-1:0] rsp_id_q;
  // Round-robin search starting just after the last granted requester; nearest wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[IW'((int'(last_q) + k) % NREQ)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((int'(last_q) + k) % NREQ);
      end
    end
  end
  assign hs        = (state_q == IDLE) && gnt_any;
  assign req_ready = (hs && rst_n) ? (NREQ'(1) << gnt_idx) : '0;
  assign ga        = req_a[256*gnt_idx +: 256];
  assign gb        = req_b[256*gnt_idx +: 256];
`ifdef ADD_SUB_ARB_RANGE_CHK_EN
  assign err_d = (ga >= P) || (gb >= P);
`else
  assign err_d = 1'b0;
`endif
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign res = op_q ? ((a_q >= b_q) ? a_q - b_q : a_q - b_q + P)
                    : ((sum >= {1'b0, P}) ? 256'(sum - {1'b0, P}) : sum[255:0]);
  // Next state: accept in IDLE, one compute cycle, hold the response until taken.
  always_comb
    state_d = (state_q == IDLE) ? (gnt_any ? EXEC : IDLE) :
              (state_q == EXEC) ? RESP :
              (state_q == RESP) ? ((rsp_valid_q && rsp_ready) ? IDLE : RESP) : IDLE;
  // State, operand capture at handshake, and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IW'(NREQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        last_q <= gnt_idx;
        a_q    <= ga;
        b_q    <= gb;
        op_q   <= req_op[gnt_idx];
        err_q  <= err_d;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= err_q ? '0 : res;
        rsp_id_q    <= last_q;
        rsp_err_q   <= err_q;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = 3'(rsp_id_q);
  assign rsp_err   = rsp_err_q;
  assign busy      = state_q != IDLE;
endmodule
